// File: rtl/vector_stream_merge.sv
// vector_stream_merge
//   Merges two valid/ready vector streams (A, B) into one output stream. Each
//   output beat is tagged with its source (out_src: 0 = A, 1 = B) so the split
//   can be re-applied downstream. Arbitration is round-robin with burst locking:
//   a granted channel keeps the grant for up to BURST accepted beats, or until it
//   drops valid. A 2-entry output buffer decouples out_ready from the input
//   readys, so there is no combinational out_ready -> x_ready path.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   a_valid    in   channel A beat valid
//   a_data     in   channel A beat [DATA_W]
//   a_ready    out  channel A beat accepted when a_valid & a_ready
//   b_valid    in   channel B beat valid
//   b_data     in   channel B beat [DATA_W]
//   b_ready    out  channel B beat accepted when b_valid & b_ready
//   out_valid  out  merged beat valid
//   out_data   out  merged beat [DATA_W]
//   out_src    out  0 = beat came from A, 1 = beat came from B
//   out_ready  in   consumer accepts when out_valid & out_ready
//
// States
//   IDLE    | no grant; arbitrate between A and B (one bubble per grant)
//   GRANT_A | A owns the input; accept A beats while buffer has room
//   GRANT_B | B owns the input; accept B beats while buffer has room

module vector_stream_merge #(
  parameter int DATA_W = 96,
  parameter int BURST  = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;     // 0 = A had the last grant, 1 = B
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] data_mem [2];
  logic              src_mem  [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              full;
  logic              push, pop;
  logic              push_src;
  logic [DATA_W-1:0] push_data;

  assign full = (count == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // With both requesting, the channel that did not hold the last grant wins.
        if (a_valid && (!b_valid || last_q)) begin
          state_d = GRANT_A;
        end else if (b_valid) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A: begin
        a_ready = !full;
        if (a_valid && !full) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BURST - 1)) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end
        end else if (!a_valid) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      GRANT_B: begin
        b_ready = !full;
        if (b_valid && !full) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BURST - 1)) begin
            state_d = IDLE;
            last_d  = 1'b1;
          end
        end else if (!b_valid) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign push      = (a_valid && a_ready) || (b_valid && b_ready);
  assign push_src  = (state_q == GRANT_B);
  assign push_data = push_src ? b_data : a_data;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_mem[0] <= '0;
      data_mem[1] <= '0;
      src_mem[0]  <= 1'b0;
      src_mem[1]  <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= push_data;
        src_mem[wr_ptr]  <= push_src;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = data_mem[rd_ptr];
  assign out_src   = src_mem[rd_ptr];

endmodule

// File: tb/tb_vector_stream_merge.sv
// Testbench for vector_stream_merge: per-channel drivers feed beats from queues,
// expected {src,data} beats are queued as stimulus is issued, and a monitor pops
// and compares on every output handshake. Directed timing checks use the recorded
// acceptance and output cycles.

module tb_vector_stream_merge;

  localparam int DW = 96;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready;
  logic          out_valid, out_src;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DW-1:0] qa[$], qb[$];
  logic [DW:0]   exp_q[$];
  int            acc_a[$], acc_b[$], out_cyc[$];
  bit            a_hs = 0, b_hs = 0;

  vector_stream_merge #(.DATA_W(DW), .BURST(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Handshakes are decided at the negedge and take effect on the next posedge.
  always @(negedge clk) begin
    a_hs = rst_n && a_valid && a_ready;
    b_hs = rst_n && b_valid && b_ready;
    if (a_hs) acc_a.push_back(cyc);
    if (b_hs) acc_b.push_back(cyc);
  end

  always @(posedge clk) begin
    if (a_hs && qa.size() > 0) void'(qa.pop_front());
    if (b_hs && qb.size() > 0) void'(qb.pop_front());
    a_hs = 0;
    b_hs = 0;
    #1;
    a_valid = (qa.size() > 0);
    a_data  = a_valid ? qa[0] : '0;
    b_valid = (qb.size() > 0);
    b_data  = b_valid ? qb[0] : '0;
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected got src=%0d data=%0h expected nothing", out_src, out_data);
      end else begin
        chk("sb_beat", {31'd0, out_src, out_data}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [DW-1:0] va(input int i);
    return DW'(32'hA00 + i);
  endfunction
  function automatic logic [DW-1:0] vb(input int i);
    return DW'(32'hB00 + i);
  endfunction

  task automatic clear_logs();
    acc_a.delete(); acc_b.delete(); out_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    qa.delete(); qb.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_left"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // 1: reset with both valids high, then A wins the first arbitration
    qa.push_back(va(0));
    qb.push_back(vb(0));
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    exp_q.push_back({1'b0, va(0)});
    exp_q.push_back({1'b1, vb(0)});
    clear_logs();
    rst_n = 1'b1;
    #1;
    chk("idle_a_ready", a_ready, 0);
    @(negedge clk);
    chk("first_grant_a_ready", a_ready, 1);
    chk("first_grant_b_ready", b_ready, 0);
    wait_drain("t1", 40);

    // 2: A only, 6 beats, bubble after the 4th
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      qa.push_back(DW'(i));
      exp_q.push_back({1'b0, DW'(i)});
    end
    wait_drain("t2", 60);
    chk("t2_acc_cnt", acc_a.size(), 6);
    chk("t2_out_cnt", out_cyc.size(), 6);
    if (acc_a.size() == 6 && out_cyc.size() == 6) begin
      for (int i = 0; i < 5; i++)
        chk($sformatf("t2_acc_gap%0d", i), acc_a[i+1] - acc_a[i], (i == 3) ? 2 : 1);
      for (int i = 0; i < 6; i++)
        chk($sformatf("t2_latency%0d", i), out_cyc[i] - acc_a[i], 1);
    end

    // 6: reset mid-burst with a full buffer (last=A before reset)
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) qa.push_back(va(20 + i));
    begin
      int n = 0;
      while (acc_a.size() < 2 && n < 30) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (2) @(negedge clk);
    chk("t6_acc_cnt", acc_a.size(), 2);
    chk("t6_full_a_ready", a_ready, 0);
    chk("t6_out_valid_pre", out_valid, 1);
    #2;
    rst_n = 1'b0;
    qa.delete(); qb.delete(); exp_q.delete();
    #1;
    chk("t6_async_out_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    rst_n = 1'b1;
    clear_logs();
    qb.push_back(vb(30));
    qa.push_back(va(30));
    exp_q.push_back({1'b0, va(30)});
    exp_q.push_back({1'b1, vb(30)});
    wait_drain("t6", 40);

    // 4: out_ready low during a grant -> buffer fills, data frozen, then drains
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      qa.push_back(va(40 + i));
      exp_q.push_back({1'b0, va(40 + i)});
    end
    repeat (8) @(negedge clk);
    chk("t4_acc_cnt", acc_a.size(), 2);
    chk("t4_a_ready", a_ready, 0);
    chk("t4_frozen_data0", out_data, va(40));
    @(negedge clk);
    chk("t4_frozen_data1", out_data, va(40));
    chk("t4_frozen_src", out_src, 0);
    out_ready = 1'b1;
    wait_drain("t4", 40);
    chk("t4_acc_total", acc_a.size(), 4);

    // 3: both continuously valid -> A4, B4, A4 with one bubble per switch
    do_reset();
    for (int i = 0; i < 8; i++) qa.push_back(va(50 + i));
    for (int i = 0; i < 4; i++) qb.push_back(vb(50 + i));
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, va(50 + i)});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, vb(50 + i)});
    for (int i = 4; i < 8; i++) exp_q.push_back({1'b0, va(50 + i)});
    wait_drain("t3", 80);
    chk("t3_acc_a_cnt", acc_a.size(), 8);
    chk("t3_acc_b_cnt", acc_b.size(), 4);
    if (acc_a.size() == 8 && acc_b.size() == 4) begin
      chk("t3_switch_ab", acc_b[0] - acc_a[3], 2);
      chk("t3_switch_ba", acc_a[4] - acc_b[3], 2);
    end

    // 5: burst cut by A dropping valid while B waits
    do_reset();
    qa.push_back(va(60)); qa.push_back(va(61));
    qb.push_back(vb(60)); qb.push_back(vb(61));
    exp_q.push_back({1'b0, va(60)});
    exp_q.push_back({1'b0, va(61)});
    exp_q.push_back({1'b1, vb(60)});
    exp_q.push_back({1'b1, vb(61)});
    wait_drain("t5", 40);
    chk("t5_acc_a_cnt", acc_a.size(), 2);
    chk("t5_acc_b_cnt", acc_b.size(), 2);
    if (acc_a.size() == 2 && acc_b.size() == 2)
      chk("t5_cut_gap", acc_b[0] - acc_a[1], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
